rr_mux_stage: RTL and testbench
===============================

Name: rr_mux_stage

Overview:
- Sequential control-and-register stage wrapped around a Mux2.
- Arbitrates round-robin between two valid/ready input streams and drives the `sel` of an external Mux2 (busSize wide).
- Captures the Mux2 output `O` into a one-entry output register with a valid/ready handshake.
- Full throughput: one transfer per cycle when the consumer keeps `out_ready` high.

Parameters:
busSize, 8, data width of both input streams, the Mux2 buses and `out_data`

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in0_valid  input  1  stream 0 offers a word (word presented on Mux2 `I1`)
- in0_ready  output  1  stream 0 word accepted this cycle
- in1_valid  input  1  stream 1 offers a word (word presented on Mux2 `I2`)
- in1_ready  output  1  stream 1 word accepted this cycle
- sel  output  1  select driven to Mux2 `sel`; 0 = `I1` (stream 0), 1 = `I2` (stream 1)
- mux_o  input  busSize  Mux2 output `O` fed back for capture
- out_valid  output  1  output register holds a word
- out_data  output  busSize  registered word
- out_ready  input  1  consumer accepts `out_data` this cycle
- last_grant  output  1  stream index of the most recent accepted word

Behaviour:
- Reset (`rst` = 1 at a clock edge):
  - `out_valid` = 0, `out_data` = 0, `last_grant` = 0, priority pointer `prio` = 0 (stream 0 preferred).
  - Reset overrides any transfer in the same cycle; a word held in the output register is dropped.
- State: 1-bit occupancy state, EMPTY (`out_valid` = 0) or FULL (`out_valid` = 1), plus the 1-bit `prio` register.
- Combinational grant:
  - Both valid -> `grant` = `prio`.
  - Only `in0_valid` -> `grant` = 0.
  - Only `in1_valid` -> `grant` = 1.
  - Neither valid -> `grant` = `prio`.
- `sel` = `grant` every cycle, combinational; no latency from the valids to `sel`.
- `space` = !`out_valid` || `out_ready`.
- `accept` = `space` && (`in0_valid` || `in1_valid`).
- `in0_ready` = `accept` && `grant` == 0; `in1_ready` = `accept` && `grant` == 1. At most one ready is high in any cycle.
- On `accept`:
  - `out_data` <= `mux_o`.
  - `out_valid` <= 1.
  - `last_grant` <= `grant`.
  - `prio` <= ~`grant` (the winner drops to low priority).
- FULL and `out_ready` = 1 and no input valid -> `out_valid` <= 0 (FULL -> EMPTY); `out_data` holds its value.
- FULL and `out_ready` = 0 -> everything holds, both readys are 0, `prio` is unchanged.
- Simultaneous drain and fill (FULL, `out_ready` = 1, an input valid) -> new word loaded; `out_valid` stays 1; no bubble.
- Latency: input accepted in cycle N -> `out_valid`/`out_data` visible in cycle N+1.
- `prio` changes only on `accept`. A lone requester therefore does not disturb fairness toward the other stream.
- `out_data` and `out_valid` must never change while `out_valid` = 1 && `out_ready` = 0.

Optional Feature:
- Macro: RR_MUX_STALL_CNT_EN.
- With the macro defined:
  - Extra output `stall_cnt` [15:0], reset 0.
  - Increments each cycle `out_valid` = 1 && `out_ready` = 0, saturating at 16'hFFFF.
  - Cleared only by `rst`.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: `rst` = 1 for 2 cycles with random inputs -> `out_valid` = 0, `out_data` = 8'h00, `last_grant` = 0, `sel` = 0 with both valids high.
- Single stream: `in0_valid` = 1 with I1 = 8'h11, 8'h22, 8'h33 on consecutive cycles, `out_ready` = 1 -> `out_data` = 11, 22, 33 on cycles 1..3 after the first accept; `last_grant` = 0 throughout; `in1_ready` = 0.
- Alternation: both valids held high, I1 = 8'hA0, I2 = 8'hB0, `out_ready` = 1 -> `sel` sequence 0, 1, 0, 1; `out_data` A0, B0, A0, B0; one accept per cycle.
- Backpressure: FULL with 8'h5A, `out_ready` = 0 for 4 cycles with both valids high -> `out_data` stays 5A, both readys 0, `prio` unchanged; `out_ready` -> 1 resumes with the correct next grant. With RR_MUX_STALL_CNT_EN defined, `stall_cnt` = 4.
- Drain to empty: FULL, valids drop, `out_ready` = 1 -> `out_valid` = 0 the next cycle; `out_data` retains its value.
- Mid-operation reset: `rst` asserted while FULL and stalled -> next cycle `out_valid` = 0, `prio` = 0; with both valids high the first post-reset grant is stream 0.

Source files
------------

// File: rtl/rr_mux_stage_if.sv
// Handshake/bus bundle between two producers, the external Mux2 and the consumer of rr_mux_stage.
// The slave modport is the stage's view. The master modport is the view of its surroundings.
interface rr_mux_stage_if #(
    parameter int busSize = 8
);
    logic               in0_valid;
    logic               in0_ready;
    logic               in1_valid;
    logic               in1_ready;
    logic               sel;
    logic [busSize-1:0] mux_o;
    logic               out_valid;
    logic [busSize-1:0] out_data;
    logic               out_ready;
    logic               last_grant;

    modport master (
        output in0_valid, in1_valid, mux_o, out_ready,
        input  in0_ready, in1_ready, sel, out_valid, out_data, last_grant
    );

    modport slave (
        input  in0_valid, in1_valid, mux_o, out_ready,
        output in0_ready, in1_ready, sel, out_valid, out_data, last_grant
    );
endinterface

// File: rtl/rr_mux_stage.sv
// Round-robin arbiter over two valid/ready streams that steers an external Mux2 and registers its output.
// Optional RR_MUX_STALL_CNT_EN adds a saturating 16-bit count of output-stall cycles.
//
// state | meaning
// EMPTY | output register holds no word (out_valid = 0)
// FULL  | output register holds a word awaiting the consumer (out_valid = 1)
module rr_mux_stage #(
    parameter int busSize = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux_stage_if.slave       bus
`ifdef RR_MUX_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               prio;
    logic               grant;
    logic               space;
    logic               accept;
    logic [busSize-1:0] data_q;
    logic               last_grant_q;

    // A lone requester wins outright; otherwise the pointer decides.
    always_comb begin
        grant = prio;
        if (bus.in0_valid && !bus.in1_valid) begin
            grant = 1'b0;
        end else if (!bus.in0_valid && bus.in1_valid) begin
            grant = 1'b1;
        end
    end

    assign space  = (state == EMPTY) || bus.out_ready;
    assign accept = space && (bus.in0_valid || bus.in1_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            prio         <= 1'b0;
            data_q       <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                prio         <= ~grant;
                data_q       <= bus.mux_o;
                last_grant_q <= grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (bus.out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.sel        = grant;
        bus.in0_ready  = accept && (grant == 1'b0);
        bus.in1_ready  = accept && (grant == 1'b1);
        bus.out_valid  = (state == FULL);
        bus.out_data   = data_q;
        bus.last_grant = last_grant_q;
    end

`ifdef RR_MUX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if ((state == FULL) && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed self-checking bench for rr_mux_stage; the bench models the external Mux2.
module tb_rr_mux_stage;
    logic       clk;
    logic       rst;
    logic [7:0] i1;
    logic [7:0] i2;
    int         errors;
    int         checks;
`ifdef RR_MUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    rr_mux_stage_if #(.busSize(8)) bus ();

    rr_mux_stage #(.busSize(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef RR_MUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    assign bus.mux_o = bus.sel ? i2 : i1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in0_valid = 1'($urandom);
        bus.in1_valid = 1'($urandom);
        bus.out_ready = 1'($urandom);
        i1 = 8'($urandom);
        i2 = 8'($urandom);
        tick();
        bus.in0_valid = 1'($urandom);
        bus.in1_valid = 1'($urandom);
        bus.out_ready = 1'($urandom);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.last_grant !== 1'b0) begin errors++; $display("FAIL reset_last_grant got=%b exp=0", bus.last_grant); end
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        #1;
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", bus.sel); end
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_stream();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i1 = vals[k];
            i2 = 8'hEE;
            #1;
            checks++; if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin errors++; $display("FAIL single_ready[%0d] got=%b%b exp=10", k, bus.in0_ready, bus.in1_ready); end
            tick();
            checks++; if (bus.out_data !== vals[k] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_data[%0d] got=%h/%b exp=%h/1", k, bus.out_data, bus.out_valid, vals[k]); end
            checks++; if (bus.last_grant !== 1'b0) begin errors++; $display("FAIL single_last_grant[%0d] got=%b exp=0", k, bus.last_grant); end
        end
        bus.in0_valid = 1'b0;
        tick();
    endtask

    task automatic test_alternation();
        logic exp_sel;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.out_ready = 1'b1;
        i1 = 8'hA0;
        i2 = 8'hB0;
        exp_sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.sel !== exp_sel) begin errors++; $display("FAIL alt_sel[%0d] got=%b exp=%b", k, bus.sel, exp_sel); end
            checks++; if (bus.in0_ready !== !exp_sel || bus.in1_ready !== exp_sel) begin errors++; $display("FAIL alt_ready[%0d] got=%b%b exp=%b%b", k, bus.in0_ready, bus.in1_ready, !exp_sel, exp_sel); end
            tick();
            checks++; if (bus.out_data !== (exp_sel ? 8'hB0 : 8'hA0) || bus.last_grant !== exp_sel) begin errors++; $display("FAIL alt_data[%0d] got=%h/%b exp=%h/%b", k, bus.out_data, bus.last_grant, exp_sel ? 8'hB0 : 8'hA0, exp_sel); end
            exp_sel = ~exp_sel;
        end
    endtask

    task automatic test_backpressure();
        // pointer is back at stream 0 after four alternating accepts
        i1 = 8'h5A;
        i2 = 8'hC3;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'h5A) begin errors++; $display("FAIL bp_load got=%h exp=5a", bus.out_data); end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0 || bus.sel !== 1'b1) begin errors++; $display("FAIL bp_hold_ctrl[%0d] got rdy=%b%b sel=%b exp rdy=00 sel=1", k, bus.in0_ready, bus.in1_ready, bus.sel); end
            tick();
            checks++; if (bus.out_data !== 8'h5A || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_data[%0d] got=%h/%b exp=5a/1", k, bus.out_data, bus.out_valid); end
        end
`ifdef RR_MUX_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=4", stall_cnt); end
`endif
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in1_ready !== 1'b1 || bus.in0_ready !== 1'b0) begin errors++; $display("FAIL bp_resume_ready got=%b%b exp=01", bus.in0_ready, bus.in1_ready); end
        tick();
        checks++; if (bus.out_data !== 8'hC3 || bus.last_grant !== 1'b1) begin errors++; $display("FAIL bp_resume_data got=%h/%b exp=c3/1", bus.out_data, bus.last_grant); end
    endtask

    task automatic test_drain();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%b%b exp=00", bus.in0_ready, bus.in1_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL drain_data got=%h exp=c3", bus.out_data); end
    endtask

    task automatic test_mid_reset();
        // lone stream 0 accept leaves the pointer at stream 1
        bus.in0_valid = 1'b1;
        i1 = 8'h77;
        tick();
        bus.in1_valid = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL mid_pre_sel got=%b exp=1", bus.sel); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
`ifdef RR_MUX_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        i1 = 8'h99;
        i2 = 8'h66;
        #1;
        checks++; if (bus.sel !== 1'b0 || bus.in0_ready !== 1'b1) begin errors++; $display("FAIL mid_grant got sel=%b rdy0=%b exp sel=0 rdy0=1", bus.sel, bus.in0_ready); end
        tick();
        checks++; if (bus.out_data !== 8'h99 || bus.last_grant !== 1'b0) begin errors++; $display("FAIL mid_data got=%h/%b exp=99/0", bus.out_data, bus.last_grant); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b0;
        i1 = 8'h00;
        i2 = 8'h00;
        test_reset();
        test_single_stream();
        test_alternation();
        test_backpressure();
        test_drain();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
